// File: rtl/rvfi_regfile_shadow_check_pkg.sv
// Shared types and helpers for the RVFI register-file shadow checker.
// Provides the error-kind encoding reported on the first-failure record,
// the RVFI register address width, and a lowest-set-bit one-hot helper
// used to pick the oldest offending retire channel.
package rvfi_check_pkg;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_RS1  = 2'd1,
        ERR_RS2  = 2'd2,
        ERR_X0   = 2'd3
    } err_kind_e;

    localparam int RVFI_AW = 5;

    // Isolates the lowest set bit (two's-complement trick).
    function automatic logic [31:0] onehot_lowest(input logic [31:0] v);
        return v & (~v + 32'd1);
    endfunction

endpackage

// File: rtl/rvfi_regfile_shadow_check_if.sv
// RVFI retire bundle observed by the register-file shadow checker.
// All fields are packed per channel, channel 0 in the least significant slice.
//   rvfi_valid/rvfi_trap           : NRET bits
//   rvfi_rd/rs1/rs2 addresses      : NRET x 5 bits
//   rvfi_rd_wdata/rs1/rs2 rdata    : NRET x XLEN bits
// master drives the bundle (core or testbench), slave observes it (checker).
interface rvfi_regfile_shadow_check_if #(
    parameter int NRET = 1,
    parameter int XLEN = 32
);
    logic [NRET-1:0]                         rvfi_valid;
    logic [NRET-1:0]                         rvfi_trap;
    logic [NRET*rvfi_check_pkg::RVFI_AW-1:0] rvfi_rd_addr;
    logic [NRET*XLEN-1:0]                    rvfi_rd_wdata;
    logic [NRET*rvfi_check_pkg::RVFI_AW-1:0] rvfi_rs1_addr;
    logic [NRET*XLEN-1:0]                    rvfi_rs1_rdata;
    logic [NRET*rvfi_check_pkg::RVFI_AW-1:0] rvfi_rs2_addr;
    logic [NRET*XLEN-1:0]                    rvfi_rs2_rdata;

    modport master (
        output rvfi_valid, rvfi_trap, rvfi_rd_addr, rvfi_rd_wdata,
               rvfi_rs1_addr, rvfi_rs1_rdata, rvfi_rs2_addr, rvfi_rs2_rdata
    );

    modport slave (
        input  rvfi_valid, rvfi_trap, rvfi_rd_addr, rvfi_rd_wdata,
               rvfi_rs1_addr, rvfi_rs1_rdata, rvfi_rs2_addr, rvfi_rs2_rdata
    );
endinterface

// File: rtl/rvfi_regfile_shadow_check_lane_cmp.sv
// Per-channel comparator for the register-file shadow checker (combinational).
// Inputs : valid/trap of the retire, rd address/data, and for each source the
//          address, read data, forwarded expected value, known bit and mask bit.
// Outputs: rs1_mismatch / rs2_mismatch when a checked, known, non-x0 source
//          read disagrees with the expected value; x0_viol when x0 is read as
//          non-zero or a non-trapping retire writes non-zero data to x0.
module rvfi_lane_cmp #(
    parameter int XLEN = 32
) (
    input  logic            valid,
    input  logic            trap,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] rd_wdata,
    input  logic [4:0]      rs1_addr,
    input  logic [XLEN-1:0] rs1_rdata,
    input  logic [XLEN-1:0] rs1_expected,
    input  logic            rs1_known,
    input  logic            rs1_mask,
    input  logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs2_rdata,
    input  logic [XLEN-1:0] rs2_expected,
    input  logic            rs2_known,
    input  logic            rs2_mask,
    output logic            rs1_mismatch,
    output logic            rs2_mismatch,
    output logic            x0_viol
);
    assign rs1_mismatch = valid && (rs1_addr != 5'd0) && rs1_mask && rs1_known
                          && (rs1_expected != rs1_rdata);
    assign rs2_mismatch = valid && (rs2_addr != 5'd0) && rs2_mask && rs2_known
                          && (rs2_expected != rs2_rdata);

    // A trapped retire never writes rd, so only its reads can violate x0.
    assign x0_viol = valid && (((rs1_addr == 5'd0) && (rs1_rdata != '0))
                            || ((rs2_addr == 5'd0) && (rs2_rdata != '0))
                            || (!trap && (rd_addr == 5'd0) && (rd_wdata != '0)));
endmodule

// File: rtl/rvfi_regfile_shadow_check.sv
// Register-file shadow checker fed from RVFI retire data.
// Keeps a shadow copy of the architectural registers plus a written[] vector,
// forwards same-cycle writes from older channels to younger reads, and flags
// source-read mismatches and x0 violations one cycle after retire.
// Ports: clk_i/rst_ni (async active-low), rvfi (slave retire bundle),
//        err_rs1_o/err_rs2_o/err_x0_o per-channel pulses, err_sticky_o,
//        first_err_kind_o/chan_o/reg_o frozen first-failure record,
//        retired_cnt_o wrapping count of valid retirements.
module rvfi_regfile_shadow_check
    import rvfi_check_pkg::*;
#(
    parameter int               NRET       = 1,
    parameter int               XLEN       = 32,
    parameter int               NREGS      = 32,
    parameter logic [NREGS-1:0] CHECK_MASK = '1,
    localparam int              AW         = $clog2(NREGS),
    localparam int              CW         = (NRET > 1) ? $clog2(NRET) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    rvfi_regfile_shadow_check_if.slave  rvfi,
    output logic [NRET-1:0]             err_rs1_o,
    output logic [NRET-1:0]             err_rs2_o,
    output logic [NRET-1:0]             err_x0_o,
    output logic                        err_sticky_o,
    output err_kind_e                   first_err_kind_o,
    output logic [CW-1:0]               first_err_chan_o,
    output logic [RVFI_AW-1:0]          first_err_reg_o,
    output logic [31:0]                 retired_cnt_o
);
    logic [RVFI_AW-1:0] rd_addr  [NRET];
    logic [RVFI_AW-1:0] rs1_addr [NRET];
    logic [RVFI_AW-1:0] rs2_addr [NRET];
    logic [XLEN-1:0]    rd_wdata [NRET];
    logic [XLEN-1:0]    rs1_exp  [NRET];
    logic [XLEN-1:0]    rs2_exp  [NRET];
    logic [NRET-1:0]    wr_en, rs1_known, rs2_known, rs1_mask, rs2_mask;
    logic [NRET-1:0]    rs1_mis, rs2_mis, x0_viol, any_err, first_oh;

    logic [XLEN-1:0]    shadow_q [NREGS];
    logic [XLEN-1:0]    shadow_d [NREGS];
    logic [NREGS-1:0]   written_q, written_d;
    logic [NRET-1:0]    err_rs1_q, err_rs2_q, err_x0_q;
    logic               sticky_q, sticky_d;
    err_kind_e          first_err_kind_q, first_err_kind_d;
    logic [CW-1:0]      first_err_chan_q, first_err_chan_d;
    logic [RVFI_AW-1:0] first_err_reg_q, first_err_reg_d;
    logic [31:0]        retired_cnt_q, retired_cnt_d;

    // Slice the packed bundle per channel and decide which channels write.
    // Out-of-range destinations are dropped rather than aliased.
    always_comb begin
        for (int c = 0; c < NRET; c++) begin
            rd_addr[c]  = rvfi.rvfi_rd_addr[c*RVFI_AW +: RVFI_AW];
            rs1_addr[c] = rvfi.rvfi_rs1_addr[c*RVFI_AW +: RVFI_AW];
            rs2_addr[c] = rvfi.rvfi_rs2_addr[c*RVFI_AW +: RVFI_AW];
            rd_wdata[c] = rvfi.rvfi_rd_wdata[c*XLEN +: XLEN];
            wr_en[c]    = rvfi.rvfi_valid[c] && !rvfi.rvfi_trap[c]
                          && (rd_addr[c] != '0) && (32'(rd_addr[c]) < NREGS);
        end
    end

    // Expected read values: start from the shadow, then let each older
    // channel writing the same register override it, so the youngest older
    // writer wins. The loop stops before c, so a channel never self-forwards.
    always_comb begin
        for (int c = 0; c < NRET; c++) begin
            rs1_exp[c]   = shadow_q[rs1_addr[c][AW-1:0]];
            rs1_known[c] = written_q[rs1_addr[c][AW-1:0]];
            rs2_exp[c]   = shadow_q[rs2_addr[c][AW-1:0]];
            rs2_known[c] = written_q[rs2_addr[c][AW-1:0]];
            rs1_mask[c]  = (32'(rs1_addr[c]) < NREGS) && CHECK_MASK[rs1_addr[c][AW-1:0]];
            rs2_mask[c]  = (32'(rs2_addr[c]) < NREGS) && CHECK_MASK[rs2_addr[c][AW-1:0]];
            for (int j = 0; j < c; j++) begin
                if (wr_en[j] && (rd_addr[j] == rs1_addr[c])) begin
                    rs1_exp[c]   = rd_wdata[j];
                    rs1_known[c] = 1'b1;
                end
                if (wr_en[j] && (rd_addr[j] == rs2_addr[c])) begin
                    rs2_exp[c]   = rd_wdata[j];
                    rs2_known[c] = 1'b1;
                end
            end
        end
    end

    for (genvar c = 0; c < NRET; c++) begin : g_lane
        rvfi_lane_cmp #(.XLEN(XLEN)) u_lane (
            .valid        (rvfi.rvfi_valid[c]),
            .trap         (rvfi.rvfi_trap[c]),
            .rd_addr      (rd_addr[c]),
            .rd_wdata     (rd_wdata[c]),
            .rs1_addr     (rs1_addr[c]),
            .rs1_rdata    (rvfi.rvfi_rs1_rdata[c*XLEN +: XLEN]),
            .rs1_expected (rs1_exp[c]),
            .rs1_known    (rs1_known[c]),
            .rs1_mask     (rs1_mask[c]),
            .rs2_addr     (rs2_addr[c]),
            .rs2_rdata    (rvfi.rvfi_rs2_rdata[c*XLEN +: XLEN]),
            .rs2_expected (rs2_exp[c]),
            .rs2_known    (rs2_known[c]),
            .rs2_mask     (rs2_mask[c]),
            .rs1_mismatch (rs1_mis[c]),
            .rs2_mismatch (rs2_mis[c]),
            .x0_viol      (x0_viol[c])
        );
    end

    // Next state: shadow/written updates in ascending channel order so the
    // highest channel wins a same-register conflict; first-error capture
    // picks the lowest offending channel, then RS1 over RS2 over X0.
    always_comb begin
        shadow_d         = shadow_q;
        written_d        = written_q;
        retired_cnt_d    = retired_cnt_q;
        first_err_kind_d = first_err_kind_q;
        first_err_chan_d = first_err_chan_q;
        first_err_reg_d  = first_err_reg_q;
        any_err          = rs1_mis | rs2_mis | x0_viol;
        first_oh         = NRET'(onehot_lowest(32'(any_err)));
        sticky_d         = sticky_q | (|any_err);
        for (int c = 0; c < NRET; c++) begin
            retired_cnt_d = retired_cnt_d + 32'(rvfi.rvfi_valid[c]);
            if (wr_en[c]) begin
                shadow_d[rd_addr[c][AW-1:0]]  = rd_wdata[c];
                written_d[rd_addr[c][AW-1:0]] = 1'b1;
            end
            if (!sticky_q && first_oh[c]) begin
                first_err_chan_d = CW'(c);
                if (rs1_mis[c]) begin
                    first_err_kind_d = ERR_RS1;
                    first_err_reg_d  = rs1_addr[c];
                end else if (rs2_mis[c]) begin
                    first_err_kind_d = ERR_RS2;
                    first_err_reg_d  = rs2_addr[c];
                end else begin
                    first_err_kind_d = ERR_X0;
                    first_err_reg_d  = '0;
                end
            end
        end
    end

    // Shadow data is deliberately unreset; written_q gates its use.
    always_ff @(posedge clk_i) begin
        shadow_q <= shadow_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            written_q        <= '0;
            err_rs1_q        <= '0;
            err_rs2_q        <= '0;
            err_x0_q         <= '0;
            sticky_q         <= 1'b0;
            first_err_kind_q <= ERR_NONE;
            first_err_chan_q <= '0;
            first_err_reg_q  <= '0;
            retired_cnt_q    <= '0;
        end else begin
            written_q        <= written_d;
            err_rs1_q        <= rs1_mis;
            err_rs2_q        <= rs2_mis;
            err_x0_q         <= x0_viol;
            sticky_q         <= sticky_d;
            first_err_kind_q <= first_err_kind_d;
            first_err_chan_q <= first_err_chan_d;
            first_err_reg_q  <= first_err_reg_d;
            retired_cnt_q    <= retired_cnt_d;
        end
    end

    assign err_rs1_o        = err_rs1_q;
    assign err_rs2_o        = err_rs2_q;
    assign err_x0_o         = err_x0_q;
    assign err_sticky_o     = sticky_q;
    assign first_err_kind_o = first_err_kind_q;
    assign first_err_chan_o = first_err_chan_q;
    assign first_err_reg_o  = first_err_reg_q;
    assign retired_cnt_o    = retired_cnt_q;

    // Each reported flag must equal the combinational check of the prior cycle.
    for (genvar c = 0; c < NRET; c++) begin : g_sva
        a_rs1: assert property (@(posedge clk_i) disable iff (!rst_ni)
                   $past(rst_ni) |-> (err_rs1_q[c] == $past(rs1_mis[c])));
        a_rs2: assert property (@(posedge clk_i) disable iff (!rst_ni)
                   $past(rst_ni) |-> (err_rs2_q[c] == $past(rs2_mis[c])));
        a_x0:  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   $past(rst_ni) |-> (err_x0_q[c] == $past(x0_viol[c])));
    end

    if (NRET > 1) begin : g_cov
        c_dep01: cover property (@(posedge clk_i) disable iff (!rst_ni)
                     wr_en[0] && rvfi.rvfi_valid[1]
                     && ((rs1_addr[1] == rd_addr[0]) || (rs2_addr[1] == rd_addr[0])));
    end
endmodule
